// File: rtl/qpsk_symbol_scheduler.sv
// QPSK symbol scheduler: 7-bit codewords -> 4 QPSK symbols per word,
// one hold register in front of the active word, TICK_DIV cycles per symbol.
module qpsk_symbol_scheduler #(
    parameter logic [15:0] AMP      = 16'h16A1,
    parameter int unsigned TICK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [6:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_real,
    output logic [15:0] out_imag,
    output logic        out_strobe,
    output logic        out_first,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_SEND   = 1'b1;
    localparam logic [7:0]  TICK_MAX = 8'(TICK_DIV - 1);
    localparam logic [15:0] NAMP     = ~AMP + 16'd1;

    logic [0:0]  state_q, state_d;
    logic        hold_valid_q, hold_valid_d;
    logic [6:0]  hold_data_q, hold_data_d;
    logic [6:0]  act_q, act_d;
    logic [7:0]  tick_q, tick_d;
    logic [1:0]  sym_q, sym_d;
    logic [15:0] words_q, words_d;

    logic       accept;
    logic       tick_end;
    logic       sending;
    logic [1:0] pair;

    // in_ready depends only on registered hold state (and reset), never on in_valid
    assign in_ready = !hold_valid_q && !rst;
    assign accept   = in_valid && in_ready;
    assign tick_end = (tick_q == TICK_MAX);
    assign sending  = (state_q == S_SEND);

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        act_d        = act_q;
        tick_d       = tick_q;
        sym_d        = sym_q;
        words_d      = words_q;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
        end
        case (state_q)
            S_IDLE: begin
                if (hold_valid_q) begin
                    state_d      = S_SEND;
                    act_d        = hold_data_q;
                    hold_valid_d = 1'b0;
                    sym_d        = 2'd0;
                    tick_d       = 8'd0;
                end
            end
            S_SEND: begin
                if (!tick_end) begin
                    tick_d = tick_q + 8'd1;
                end else begin
                    tick_d = 8'd0;
                    if (sym_q != 2'd3) begin
                        sym_d = sym_q + 2'd1;
                    end else begin
                        words_d = words_q + 16'd1;
                        sym_d   = 2'd0;
                        if (hold_valid_q) begin
                            act_d        = hold_data_q;
                            hold_valid_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 7'd0;
            act_q        <= 7'd0;
            tick_q       <= 8'd0;
            sym_q        <= 2'd0;
            words_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            act_q        <= act_d;
            tick_q       <= tick_d;
            sym_q        <= sym_d;
            words_q      <= words_d;
        end
    end

    always_comb begin
        case (sym_q)
            2'd0:    pair = act_q[6:5];
            2'd1:    pair = act_q[4:3];
            2'd2:    pair = act_q[2:1];
            default: pair = {act_q[0], 1'b0};
        endcase
    end

    assign out_valid  = sending;
    assign out_real   = sending ? (pair[0] ? NAMP : AMP) : 16'h0000;
    assign out_imag   = sending ? (pair[1] ? NAMP : AMP) : 16'h0000;
    assign out_strobe = sending && (tick_q == 8'd0);
    assign out_first  = sending && (sym_q == 2'd0);
    assign out_last   = sending && (sym_q == 2'd3);
    assign busy       = sending || hold_valid_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Bench for qpsk_symbol_scheduler: directed scenarios plus random words,
// checked against a per-codeword symbol table built from the mapping rules.
module tb_qpsk_symbol_scheduler;

    localparam logic [15:0] AMP  = 16'h16A1;
    localparam logic [15:0] NAMP = 16'h0000 - AMP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic [6:0]  id = 7'd0;
    logic        ir, ov, ost, ofi, ola, bsy;
    logic [15:0] ore, oim, ws;

    logic        v1 = 1'b0;
    logic [6:0]  d1 = 7'd0;
    logic        rdy1, val1, stb1, fst1, lst1, bsy1;
    logic [15:0] re1, im1, ws1;

    qpsk_symbol_scheduler #(.AMP(AMP), .TICK_DIV(8)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_data(id),
        .in_ready(ir), .out_valid(ov), .out_real(ore), .out_imag(oim),
        .out_strobe(ost), .out_first(ofi), .out_last(ola),
        .busy(bsy), .words_sent(ws)
    );

    qpsk_symbol_scheduler #(.AMP(AMP), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1),
        .in_ready(rdy1), .out_valid(val1), .out_real(re1), .out_imag(im1),
        .out_strobe(stb1), .out_first(fst1), .out_last(lst1),
        .busy(bsy1), .words_sent(ws1)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int run = 0;
    int last_run = 0;

    logic [33:0] exp_q[$];
    int          st_cyc[$];
    logic [31:0] sym_log[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // symbol k of codeword cw as {real, imag}
    function automatic logic [31:0] sym_of(input logic [6:0] cw, input int k);
        logic [7:0] ext;
        int pr;
        ext = {cw, 1'b0};
        pr = int'(ext >> (6 - 2 * k)) % 4;
        return {(pr % 2 == 1) ? NAMP : AMP, (pr / 2 == 1) ? NAMP : AMP};
    endfunction

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (ov === 1'b1) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (ov === 1'b1 && ost === 1'b1) begin
                st_cyc.push_back(cyc);
                sym_log.push_back({ore, oim});
                if (exp_q.size() == 0) chk("unexpected_symbol", 1, 0);
                else chk("symbol", {ofi, ola, ore, oim}, exp_q.pop_front());
            end
            if (ov === 1'b0) chk("idle_outputs", {ost, ofi, ola, ore, oim}, 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        iv = 1'b0;
        v1 = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        run = 0;
        @(negedge clk);
        chk("rst_valid", ov, 0);
        chk("rst_busy", bsy, 0);
        chk("rst_ready", ir, 0);
        chk("rst_words", ws, 0);
        chk("rst_outs", {ost, ofi, ola, ore, oim}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", ir, 1);
        st_cyc.delete();
        sym_log.delete();
        mon_en = 1'b1;
    endtask

    task automatic send(input logic [6:0] cw, output int acc, output int waited);
        int t;
        t = 0;
        @(negedge clk);
        iv = 1'b1;
        id = cw;
        while (ir !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        if (ir !== 1'b1) begin
            chk("accept_timeout", 0, 1);
            iv = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        for (int k = 0; k < 4; k++)
            exp_q.push_back({k == 0, k == 3, sym_of(cw, k)});
        @(negedge clk);
        iv = 1'b0;
        id = ~cw;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (bsy !== 1'b0 && t < budget);
        chk("idle_timeout", bsy, 0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int acc_a, acc_b, acc_c, w;
        logic [6:0] cw;
        logic [31:0] lit[4];
        logic [6:0] w1[3];
        logic [31:0] rec[12];
        int nrec, fc, lc, nstb, wi;

        lit[0] = 32'h16A116A1;
        lit[1] = 32'hE95FE95F;
        lit[2] = 32'hE95F16A1;
        lit[3] = 32'h16A1E95F;

        // single codeword; in_data flipped right after acceptance
        do_reset();
        send(7'b0011011, acc_a, w);
        wait_idle(200);
        chk("s1_nsym", st_cyc.size(), 4);
        if (st_cyc.size() == 4) begin
            chk("s1_latency", st_cyc[0], acc_a + 1);
            for (int k = 1; k < 4; k++)
                chk("s1_spacing", st_cyc[k] - st_cyc[k-1], 8);
            for (int k = 0; k < 4; k++)
                chk("s1_value", sym_log[k], lit[k]);
        end
        chk("s1_words", ws, 1);
        chk("s1_run", last_run, 32);
        chk("s1_drained", exp_q.size(), 0);

        // two codewords back-to-back
        do_reset();
        send(7'($urandom), acc_a, w);
        send(7'($urandom), acc_b, w);
        wait_idle(300);
        chk("s2_nsym", st_cyc.size(), 8);
        if (st_cyc.size() == 8)
            chk("s2_gap", st_cyc[4] - st_cyc[3], 8);
        chk("s2_run", last_run, 64);
        chk("s2_words", ws, 2);

        // third word stalls on a full hold register
        do_reset();
        send(7'($urandom), acc_a, w);
        send(7'($urandom), acc_b, w);
        send(7'($urandom), acc_c, w);
        chk("s3_stalled", w > 0, 1);
        wait_idle(400);
        chk("s3_nsym", st_cyc.size(), 12);
        if (st_cyc.size() == 12)
            chk("s3_accept_edge", acc_c, st_cyc[4] + 1);
        chk("s3_words", ws, 3);
        chk("s3_drained", exp_q.size(), 0);
        chk("s3_run", last_run, 96);

        // reset during sym2
        do_reset();
        send(7'($urandom), acc_a, w);
        for (int t = 0; t < 100 && st_cyc.size() < 3; t++) begin
            @(posedge clk);
            #1;
        end
        chk("s4_reached_sym2", st_cyc.size(), 3);
        do_reset();
        cw = 7'($urandom);
        send(cw, acc_a, w);
        wait_idle(200);
        chk("s4_nsym", sym_log.size(), 4);
        if (sym_log.size() == 4)
            chk("s4_sym0", sym_log[0], sym_of(cw, 0));
        chk("s4_words", ws, 1);

        // random words with random gaps
        do_reset();
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            send(7'($urandom), acc_a, w);
        end
        wait_idle(600);
        chk("rand_nsym", st_cyc.size(), 20);
        chk("rand_words", ws, 5);
        chk("rand_drained", exp_q.size(), 0);

        // TICK_DIV=1 streaming on the second instance
        for (int i = 0; i < 3; i++) w1[i] = 7'($urandom);
        nrec = 0;
        fc = -1;
        lc = -1;
        nstb = 0;
        wi = 0;
        @(negedge clk);
        v1 = 1'b1;
        d1 = w1[0];
        for (int c = 0; c < 60; c++) begin
            if (val1 === 1'b1) begin
                if (nrec < 12) rec[nrec] = {re1, im1};
                nrec++;
                if (fc < 0) fc = c;
                lc = c;
                if (stb1 === 1'b1) nstb++;
            end
            if (v1 && rdy1 === 1'b1) begin
                wi++;
                @(negedge clk);
                v1 = (wi < 3);
                d1 = ~d1;
                if (wi < 3) d1 = w1[wi];
            end else begin
                @(negedge clk);
            end
        end
        chk("td1_nvalid", nrec, 12);
        chk("td1_contig", lc - fc, 11);
        chk("td1_nstrobe", nstb, 12);
        for (int i = 0; i < 12 && i < nrec; i++)
            chk("td1_symbol", rec[i], sym_of(w1[i/4], i % 4));
        chk("td1_words", ws1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
